tournament_predictor_v2: RTL

// Parametrised tournament branch predictor for the instruction queue. Combines a two-level local

---
 rtl/tournament_predictor_v2.sv | 122 ++++++++++++
 1 files changed

// File: rtl/tournament_predictor_v2.sv
// Tournament branch predictor: a two-level local predictor and a gshare global predictor, arbitrated per PC
// by a chooser, with a speculative global history that is restored on mispredict.
module tournament_predictor_v2 #(
    parameter int ADDR_W  = 17,
    parameter int IDX_W   = 10,
    parameter int LHIST_W = 10,
    parameter int GHIST_W = 10,
    parameter int CTR_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_valid,
    input  logic [ADDR_W-1:0]  q_address,
    output logic               q_take,
    output logic [GHIST_W-1:0] q_ghist,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_address,
    input  logic               br_take,
    input  logic [GHIST_W-1:0] br_ghist,
    input  logic               br_mispredict,
    output logic [31:0]        perf_branches,
    output logic [31:0]        perf_mispred
);
    localparam int LHT_N  = 1 << IDX_W;
    localparam int LPHT_N = 1 << LHIST_W;
    localparam int GPHT_N = 1 << GHIST_W;

    logic [LHIST_W-1:0] lht     [LHT_N];
    logic [1:0]         chooser [LHT_N];
    logic [CTR_W-1:0]   lpht    [LPHT_N];
    logic [CTR_W-1:0]   gpht    [GPHT_N];
    logic [GHIST_W-1:0] ghist;

    logic [IDX_W-1:0]   li, bi;
    logic [GHIST_W-1:0] gi, gj;
    logic [LHIST_W-1:0] h;
    logic [CTR_W-1:0]   lp, gp, lc, gc;
    logic [1:0]         ch, ch_next;
    logic               local_right, global_right, restore;
    logic               unused_addr_bits;

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
        if (up) return (c == '1) ? c : c + 1'b1;
        else    return (c == '0) ? c : c - 1'b1;
    endfunction

    // Query path: all arrays are read with their pre-edge contents.
    assign li      = q_address[IDX_W-1:0];
    assign lp      = lpht[lht[li]];
    assign gi      = ghist ^ q_address[GHIST_W-1:0];
    assign gp      = gpht[gi];
    assign q_take  = chooser[li][1] ? lp[CTR_W-1] : gp[CTR_W-1];
    assign q_ghist = ghist;

    // Commit path: every index comes from the br_* values, never from the live ghist.
    assign bi           = br_address[IDX_W-1:0];
    assign h            = lht[bi];
    assign gj           = br_ghist ^ br_address[GHIST_W-1:0];
    assign lc           = lpht[h];
    assign gc           = gpht[gj];
    assign ch           = chooser[bi];
    assign local_right  = (lc[CTR_W-1] == br_take);
    assign global_right = (gc[CTR_W-1] == br_take);
    assign restore      = br_valid & br_mispredict;
    assign unused_addr_bits = ^{q_address, br_address};

    always_comb begin
        ch_next = ch;
        if (local_right && !global_right && ch != 2'b11)
            ch_next = ch + 2'd1;
        else if (global_right && !local_right && ch != 2'b00)
            ch_next = ch - 2'd1;
    end

    // A mispredict restore wins over a same-cycle wrong-path query shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ghist <= '0;
        else if (restore)
            ghist <= {br_ghist[GHIST_W-2:0], br_take};
        else if (q_valid)
            ghist <= {ghist[GHIST_W-2:0], q_take};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LHT_N; i++) begin
                lht[i]     <= '0;
                chooser[i] <= 2'b01;
            end
        end else if (br_valid) begin
            lht[bi]     <= {h[LHIST_W-2:0], br_take};
            chooser[bi] <= ch_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LPHT_N; i++) lpht[i] <= '0;
        end else if (br_valid) begin
            lpht[h] <= ctr_step(lc, br_take);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < GPHT_N; i++) gpht[i] <= '0;
        end else if (br_valid) begin
            gpht[gj] <= ctr_step(gc, br_take);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else begin
            if (br_valid) perf_branches <= perf_branches + 32'd1;
            if (restore)  perf_mispred  <= perf_mispred + 32'd1;
        end
    end
endmodule
